// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I widths, reset defaults and the fetch-entry layout
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous response buffer with push/pop/clear and occupancy count
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       push_data,
    input  logic                     pop,
    output logic [ENTRY_W-1:0]       pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full && !clear;
    assign do_pop   = pop && !empty && !clear;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: count/pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I IF stage and IF/ID register with credit-limited imem fetch
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE     = 1;

    logic [XLEN-1:0]    pcf;
    logic [XLEN-1:0]    rsp_pc;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      drop;
    logic [CW-1:0]      fifo_count;
    logic [CW:0]        in_use;
    logic               req_fire;
    logic               rsp_fire;
    logic               push;
    logic               pop;
    logic               bubble;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head;
    fetch_entry_t       head_entry;

    // Requests in flight plus buffered entries never exceed the FIFO, so a response always has room.
    assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = rst_n && !pc_src_e && (in_use < DEPTH_W);
    assign imem_req_addr  = pcf;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (outstanding != '0);
    assign push           = rsp_fire && (drop == '0) && !pc_src_e;
    assign push_data      = {rsp_pc, imem_rsp_data};
    assign bubble         = flush_d || pc_src_e;
    assign pop            = !bubble && !stall_d && !fifo_empty;
    assign head_entry     = head;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pc_src_e),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf         <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + {{(CW-1){1'b0}}, req_fire} - {{(CW-1){1'b0}}, rsp_fire};
            if (pc_src_e) begin
                // Everything still in flight after this cycle belongs to the old path.
                pcf    <= pc_target_e;
                rsp_pc <= pc_target_e;
                drop   <= outstanding - {{(CW-1){1'b0}}, rsp_fire};
            end else begin
                if (req_fire) pcf <= pcf + 32'd4;
                if (push)     rsp_pc <= rsp_pc + 32'd4;
                if (rsp_fire && (drop != '0)) drop <= drop - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (bubble) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (!stall_d) begin
            if (!fifo_empty) begin
                instr_d    <= head_entry.instr;
                pc_d       <= head_entry.pc;
                pc_plus4_d <= head_entry.pc + 32'd4;
                valid_d    <= 1'b1;
            end else begin
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
            end
        end
    end

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outstanding != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> !fifo_full);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        stall_d;
    logic        flush_d;
    logic        pc_src_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .pc_src_e       (pc_src_e),
        .pc_target_e    (pc_target_e),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pc_plus4_d     (pc_plus4_d),
        .valid_d        (valid_d)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // In-order memory: a request taken at one edge answers in the following cycle unless held.
    logic [31:0] q[$];
    logic        mem_hold = 1'b0;
    int          fetch_0x10 = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            imem_rsp_valid = 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                q.push_back(imem_req_addr);
                if (imem_req_addr == 32'h10) fetch_0x10++;
            end
            #2;
            if (!mem_hold && q.size() > 0) begin
                imem_rsp_data  = mem_word(q.pop_front());
                imem_rsp_valid = 1'b1;
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid_d && n < 20);
        check_eq(tag, {31'd0, valid_d}, 32'd1);
    endtask

    task automatic check_d(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, {31'd0, valid_d}, 32'd1);
        check_eq({tag, "_pc"}, pc_d, pc);
        check_eq({tag, "_instr"}, instr_d, mem_word(pc));
        check_eq({tag, "_pc4"}, pc_plus4_d, pc + 32'd4);
    endtask

    task automatic check_bubble(input string tag);
        check_eq({tag, "_valid"}, {31'd0, valid_d}, 32'd0);
        check_eq({tag, "_instr"}, instr_d, 32'h0000_0013);
    endtask

    initial begin
        imem_req_ready = 1'b1;
        stall_d        = 1'b0;
        flush_d        = 1'b0;
        pc_src_e       = 1'b0;
        pc_target_e    = '0;

        // 1: reset values, first fetches and 3-cycle latency
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_bubble("rst");
        check_eq("rst_pc_d", pc_d, 32'h0);
        check_eq("rst_pc4", pc_plus4_d, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("c0_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check_eq("c0_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        check_eq("c1_addr", imem_req_addr, 32'h4);
        check_eq("c1_valid", {31'd0, valid_d}, 32'd0);
        @(negedge clk);
        check_eq("c2_valid", {31'd0, valid_d}, 32'd0);
        @(negedge clk);
        check_d("c3", 32'h0);
        @(negedge clk);
        check_d("c4", 32'h4);
        check_eq("c4_addr", imem_req_addr, 32'h10);

        // 2: memory not ready for 5 cycles at 0x10
        imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_addr", imem_req_addr, 32'h10);
            check_eq("hold_req_valid", {31'd0, imem_req_valid}, 32'd1);
        end
        check_bubble("drained");
        imem_req_ready = 1'b1;
        wait_valid("t2_seen");
        check_d("t2_resume", 32'h10);

        // 3: stall for 3 cycles until credit runs out
        @(negedge clk);
        check_d("t3_pre", 32'h14);
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_d("stall", 32'h14);
        end
        check_eq("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check_eq("stall_addr", imem_req_addr, 32'h28);
        stall_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_d("post_stall", 32'h18 + 32'(4 * i));
        end
        check_eq("fetch_0x10_once", 32'(fetch_0x10), 32'd1);

        // 4: redirect with two requests in flight, then redirect while streaming with stall
        @(negedge clk);
        rst_n    = 1'b0;
        mem_hold = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        pc_src_e    = 1'b1;
        pc_target_e = 32'h100;
        #1;
        check_eq("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        check_bubble("redir_bubble");
        pc_src_e = 1'b0;
        mem_hold = 1'b0;
        #1;
        check_eq("redir_addr", imem_req_addr, 32'h100);
        wait_valid("t4_seen");
        check_d("redir_first", 32'h100);
        @(negedge clk);
        check_d("redir_second", 32'h104);
        pc_src_e    = 1'b1;
        pc_target_e = 32'h200;
        stall_d     = 1'b1;
        @(negedge clk);
        check_bubble("redir_stall");
        check_eq("redir_stall_pc", pc_d, 32'h104);
        pc_src_e = 1'b0;
        stall_d  = 1'b0;
        wait_valid("t4b_seen");
        check_d("redir2_first", 32'h200);
        @(negedge clk);
        check_d("redir2_second", 32'h204);

        // 5: flush and stall together
        flush_d = 1'b1;
        stall_d = 1'b1;
        @(negedge clk);
        check_bubble("flush_stall");
        flush_d = 1'b0;
        stall_d = 1'b0;
        wait_valid("t5_seen");
        check_d("after_flush", 32'h208);

        // 6: one-cycle asynchronous reset mid-stream, then PC wrap
        rst_n = 1'b0;
        #1;
        check_bubble("async_rst");
        check_eq("async_rst_pc", pc_d, 32'h0);
        check_eq("async_rst_pc4", pc_plus4_d, 32'h0);
        check_eq("async_rst_req", {31'd0, imem_req_valid}, 32'd0);
        check_eq("async_rst_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("t6_seen");
        check_d("restart", 32'h0);
        pc_src_e    = 1'b1;
        pc_target_e = 32'hFFFF_FFF8;
        @(negedge clk);
        pc_src_e = 1'b0;
        wait_valid("wrap_seen");
        check_d("wrap0", 32'hFFFF_FFF8);
        @(negedge clk);
        check_d("wrap1", 32'hFFFF_FFFC);
        @(negedge clk);
        check_d("wrap2", 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
